// File: rtl/calc_pkg.sv
// Shared definitions for the 8-bit calculator, its tester and the result buffer.
package calc_pkg;

  localparam int ANCHO   = 8;
  localparam int MODO_W  = 2;
  localparam int ENTRY_W = ANCHO + MODO_W;

  // One stage of the request tag pipeline: the strobe plus the mode it carried.
  typedef struct packed {
    logic              en;
    logic [MODO_W-1:0] modo;
  } tag_t;

  // A stored result; the mode is kept in the low bits.
  typedef struct packed {
    logic [ANCHO-1:0]  data;
    logic [MODO_W-1:0] modo;
  } entry_t;

endpackage

// File: rtl/calc_fifo.sv
// Generic first-word-fall-through FIFO with an explicitly tracked occupancy count.
// The head entry is presented combinationally from storage and reads as zero while empty.
module calc_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Status is decoded only from the registered count, so no input reaches it combinationally.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    dout  = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Qualify requests: pop needs data, push needs room (a simultaneous pop frees a slot).
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; stale contents are hidden behind the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/calc_result_buffer.sv
// Captures each calculator result LAT cycles after its request and queues it, with its
// mode tag, for a valid/ready consumer. Drops on a full queue are recorded in a sticky flag.
module calc_result_buffer #(
  parameter int ANCHO = calc_pkg::ANCHO,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   MODO,
  input  logic [ANCHO-1:0]             c,
  input  logic                         clr_ovf,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [ANCHO-1:0]             out_data,
  output logic [1:0]                   out_modo,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);
  import calc_pkg::*;

  localparam int EW = ANCHO + MODO_W;

  tag_t          tag_q [LAT];
  tag_t          tag_d [LAT];
  logic          overflow_q, overflow_d;
  logic          capture;
  logic          push;
  logic          pop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;

  // Shift {en, MODO} down the pipeline; the last stage lines up with the result on c.
  always_comb begin
    tag_d[0] = '{en: en, modo: MODO};
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag pipeline registers; reset discards any request still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Handshake and drop gating: a capture is pushed only if there is room or a pop frees it.
  always_comb begin
    capture    = tag_q[LAT-1].en;
    pop        = out_valid && out_ready;
    push       = capture && (!full || pop);
    push_entry = {c, tag_q[LAT-1].modo};
  end

  // Sticky overflow: a dropped capture sets it and beats a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (capture && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  calc_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Split the head entry back into result and tag for the consumer.
  always_comb begin
    out_valid = !empty;
    out_data  = head_entry[EW-1:MODO_W];
    out_modo  = head_entry[MODO_W-1:0];
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_calc_result_buffer.sv
// Self-checking bench for calc_result_buffer: directed scenarios plus a randomized run
// compared against a queue-based model of the capture/FIFO rules.
module tb_calc_result_buffer;

  localparam int ANCHO = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       MODO;
  logic [ANCHO-1:0] c;
  logic             clr_ovf;
  logic             out_ready;
  logic             out_valid;
  logic [ANCHO-1:0] out_data;
  logic [1:0]       out_modo;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: requests waiting for their result, the queued entries, the flag.
  int         pend_due [$];
  logic [1:0] pend_modo[$];
  logic [9:0] mq[$];
  logic       m_ovf;
  int         edge_n = 0;

  calc_result_buffer #(
    .ANCHO (ANCHO),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .MODO      (MODO),
    .c         (c),
    .clr_ovf   (clr_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_modo  (out_modo),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    pend_due.delete();
    pend_modo.delete();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // Advance one rising edge and apply the same edge to the model, then settle 1 time unit.
  task automatic tick();
    bit         cap;
    bit         popped;
    logic [1:0] cm;
    cap = 0;
    cm  = 2'b00;
    @(posedge clk);
    edge_n++;
    if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
      cap = 1;
      cm  = pend_modo.pop_front();
      void'(pend_due.pop_front());
    end
    popped = (mq.size() > 0) && out_ready;
    if (popped) void'(mq.pop_front());
    if (clr_ovf) m_ovf = 1'b0;
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back({c, cm});
      else m_ovf = 1'b1;
    end
    if (en) begin
      pend_due.push_back(edge_n + LAT);
      pend_modo.push_back(MODO);
    end
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; MODO = 2'b00; c = '0; clr_ovf = 0; out_ready = 0;
  endtask

  // Stimulus helper: queue four captures with data base..base+3 (no checking here).
  task automatic fill_four(input logic [7:0] base);
    en = 1; MODO = 2'b10;
    tick();
    for (int i = 0; i < 4; i++) begin
      en = (i < 3);
      c  = base + 8'(i);
      tick();
    end
    en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL reset_valid got=%b want=0", out_valid); failures++; end
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      $display("[TB] FAIL reset_status got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); failures++;
    end
    checks++;
    if (overflow !== 1'b0 || out_data !== 8'h00 || out_modo !== 2'b00) begin
      $display("[TB] FAIL reset_outputs got ovf=%b data=%h modo=%b want 0/00/00", overflow, out_data, out_modo); failures++;
    end
    checks++;
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic test_single_capture();
    en = 1; MODO = 2'b01;
    tick();
    en = 0; MODO = 2'b00; c = 8'h2A;
    tick();
    if (out_valid !== 1'b1 || count !== CW'(1)) begin
      $display("[TB] FAIL single_valid got valid=%b count=%0d want 1/1", out_valid, count); failures++;
    end
    checks++;
    if (out_data !== 8'h2A || out_modo !== 2'b01) begin
      $display("[TB] FAIL single_head got %h/%b want 2a/01", out_data, out_modo); failures++;
    end
    checks++;
    out_ready = 1;
    tick();
    out_ready = 0;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      $display("[TB] FAIL single_pop got empty=%b valid=%b want 1/0", empty, out_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    fill_four(8'h01);
    if (full !== 1'b1 || count !== CW'(4)) begin
      $display("[TB] FAIL b2b_full got full=%b count=%0d want 1/4", full, count); failures++;
    end
    checks++;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
        $display("[TB] FAIL b2b_order[%0d] got valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(i + 1)); failures++;
      end
      checks++;
      tick();
    end
    out_ready = 0;
    if (empty !== 1'b1) begin $display("[TB] FAIL b2b_empty got %b want 1", empty); failures++; end
    checks++;
  endtask

  task automatic test_overflow();
    fill_four(8'h01);
    en = 1;
    tick();
    en = 0; c = 8'hFF;
    tick();
    if (overflow !== 1'b1) begin $display("[TB] FAIL ovf_set got %b want 1", overflow); failures++; end
    checks++;
    if (count !== CW'(4) || out_data !== 8'h01) begin
      $display("[TB] FAIL ovf_hold got count=%0d head=%h want 4/01", count, out_data); failures++;
    end
    checks++;
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    if (overflow !== 1'b0) begin $display("[TB] FAIL ovf_clear got %b want 0", overflow); failures++; end
    checks++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last;
    en = 1;
    tick();
    en = 0; c = 8'h55; out_ready = 1;
    tick();
    out_ready = 0;
    if (overflow !== 1'b0 || count !== CW'(4)) begin
      $display("[TB] FAIL fullpp_count got ovf=%b count=%0d want 0/4", overflow, count); failures++;
    end
    checks++;
    out_ready = 1;
    last = 8'h00;
    for (int i = 0; i < 4; i++) begin
      last = out_data;
      tick();
    end
    out_ready = 0;
    if (last !== 8'h55 || empty !== 1'b1) begin
      $display("[TB] FAIL fullpp_last got last=%h empty=%b want 55/1", last, empty); failures++;
    end
    checks++;
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] got[$];
    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      en = (i < 10);
      MODO = 2'(i);
      c = (i >= 1) ? 8'(i - 1) : 8'h00;
      if (out_valid) got.push_back(out_data);
      tick();
    end
    en = 0; out_ready = 0;
    if (got.size() != 10) begin
      $display("[TB] FAIL wrap_len got %0d entries want 10", got.size()); failures++;
    end
    checks++;
    for (int i = 0; i < got.size() && i < 10; i++) begin
      if (got[i] !== 8'(i)) begin
        $display("[TB] FAIL wrap_order[%0d] got %h want %h", i, got[i], 8'(i)); failures++;
      end
      checks++;
    end
  endtask

  task automatic test_reset_midflight();
    en = 1; MODO = 2'b11;
    tick();
    en = 0;
    #2 rst = 0;
    model_clear();
    #2 rst = 1;
    c = 8'hAA;
    tick();
    if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      $display("[TB] FAIL midreset got count=%0d valid=%b ovf=%b want 0/0/0", count, out_valid, overflow); failures++;
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      MODO      = 2'($urandom);
      c         = 8'($urandom);
      out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      tick();
      if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        $display("[TB] FAIL rand_count@%0d got count=%0d full=%b empty=%b want count=%0d", i, count, full, empty, mq.size());
        failures++;
      end
      checks++;
      if (overflow !== m_ovf) begin
        $display("[TB] FAIL rand_ovf@%0d got %b want %b", i, overflow, m_ovf); failures++;
      end
      checks++;
      if (mq.size() > 0) begin
        if (out_valid !== 1'b1 || {out_data, out_modo} !== mq[0]) begin
          $display("[TB] FAIL rand_head@%0d got valid=%b %h/%b want 1 %h/%b", i, out_valid, out_data, out_modo, mq[0][9:2], mq[0][1:0]);
          failures++;
        end
        checks++;
      end else begin
        if (out_valid !== 1'b0) begin
          $display("[TB] FAIL rand_valid@%0d got %b want 0", i, out_valid); failures++;
        end
        checks++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_single_capture();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_pointer_wrap();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
